// File: rtl/lsu_byte_master.sv
// Load/store initiator that breaks one CPU access into 1, 2 or 4 little-endian byte transactions.
// Optional build macro MISALIGN_TRAP_EN: reject misaligned h/hu/w requests instead of splitting them.
module lsu_byte_master #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [2:0]        i_req_func3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [7:0]        i_mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam int TCW = 16;

  logic [1:0]        r_state;
  logic              r_write;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_last;
  logic [1:0]        r_idx;
  logic [TCW-1:0]    r_tcnt;
  logic [31:0]       r_buf;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;

  logic              w_bad;
  logic [1:0]        w_last;
  logic [1:0]        w_next_idx;
  logic [31:0]       w_ext;

  always_comb begin
    w_bad = (i_req_func3 == 3'b011) || (i_req_func3 == 3'b110) ||
            (i_req_func3 == 3'b111) || (i_req_write && i_req_func3[2]);
`ifdef MISALIGN_TRAP_EN
    if ((i_req_func3[1:0] == 2'b01) && i_req_addr[0])
      w_bad = 1'b1;
    if ((i_req_func3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00))
      w_bad = 1'b1;
`endif
    case (i_req_func3[1:0])
      2'b00:   w_last = 2'd0;
      2'b01:   w_last = 2'd1;
      default: w_last = 2'd3;
    endcase
    w_next_idx = r_idx + 2'd1;
    case (r_func3)
      3'b000:  w_ext = {{24{r_buf[7]}}, r_buf[7:0]};
      3'b001:  w_ext = {{16{r_buf[15]}}, r_buf[15:0]};
      3'b100:  w_ext = {24'd0, r_buf[7:0]};
      3'b101:  w_ext = {16'd0, r_buf[15:0]};
      default: w_ext = r_buf;
    endcase
  end

  // One byte per ack; the response is registered in RESP so it appears the cycle after.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_func3      <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_last       <= 2'd0;
      r_idx        <= 2'd0;
      r_tcnt       <= '0;
      r_buf        <= 32'd0;
      r_err        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write <= i_req_write;
            r_func3 <= i_req_func3;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_last  <= w_last;
            r_idx   <= 2'd0;
            r_tcnt  <= '0;
            r_buf   <= 32'd0;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err       <= 1'b0;
              r_state     <= S_ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_req_write;
              r_mem_addr  <= i_req_addr;
              r_mem_wdata <= i_req_wdata[7:0];
            end
          end
        end
        S_ACCESS: begin
          if (i_mem_ack) begin
            r_buf[{r_idx, 3'b000} +: 8] <= i_mem_rdata;
            r_tcnt <= '0;
            if (r_idx == r_last) begin
              r_mem_req <= 1'b0;
              r_state   <= S_RESP;
            end else begin
              r_idx       <= w_next_idx;
              r_mem_addr  <= r_addr + ADDR_W'(w_next_idx);
              r_mem_wdata <= r_wdata[{w_next_idx, 3'b000} +: 8];
            end
          end else if ((TIMEOUT != 0) && (r_tcnt == TCW'(TIMEOUT - 1))) begin
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_resp_rdata <= (r_err || r_write) ? 32'd0 : w_ext;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed bench for lsu_byte_master: vector table against a byte memory model, plus
// timeout and mid-operation reset sequences. Honours MISALIGN_TRAP_EN when defined.
module tb_lsu_byte_master;

  localparam int AW = 6;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
    int          expBytes;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [2:0]    reqFunc3;
  logic [AW-1:0] reqAddr;
  logic [31:0]   reqWdata;
  logic          respValid;
  logic [31:0]   respRdata;
  logic          respErr;
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [7:0]    memWdata;
  logic          memAck;
  logic [7:0]    memRdata;

  logic [7:0]    mem [64];
  logic          ackEn;
  logic [AW-1:0] ackLog [$];
  int            total = 0;
  int            bad = 0;
  vec_t          vecs [15];

  lsu_byte_master #(.ADDR_W(AW), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_write(reqWrite),
    .i_req_func3(reqFunc3), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_resp_valid(respValid), .o_resp_rdata(respRdata), .o_resp_err(respErr),
    .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_ack(memAck), .i_mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  assign memAck   = ackEn & memReq;
  assign memRdata = mem[memAddr];

  // Byte memory: acknowledges in the same cycle as the request when enabled.
  always @(posedge clk) begin
    if (memReq && memAck) begin
      ackLog.push_back(memAddr);
      if (memWe) mem[memAddr] = memWdata;
    end
  end

  function automatic vec_t mk(logic wr, logic [2:0] f3, logic [5:0] a, logic [31:0] wd,
                              logic [31:0] ed, logic ee, int lat, int nb);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.expData = ed; v.expErr = ee; v.expLat = lat; v.expBytes = nb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    logic got;
    @(negedge clk);
    ackLog.delete();
    reqValid = 1'b1; reqWrite = v.wr; reqFunc3 = v.f3; reqAddr = v.addr; reqWdata = v.wdata;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk);
      #1;
      if (respValid) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int lat;
    logic [31:0] heldData;
    applyStimulus(v, lat);
    checkOutput({tag, " latency"}, lat, v.expLat);
    checkOutput({tag, " rdata"}, respRdata, v.expData);
    checkOutput({tag, " err"}, {31'd0, respErr}, {31'd0, v.expErr});
    checkOutput({tag, " bytes"}, ackLog.size(), v.expBytes);
    for (int k = 0; k < ackLog.size() && k < v.expBytes; k++) begin
      logic [5:0] ea;
      ea = v.addr + 6'(k);
      checkOutput($sformatf("%s addr%0d", tag, k), {26'd0, ackLog[k]}, {26'd0, ea});
    end
    heldData = v.expData;
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse"}, {31'd0, respValid}, 32'd0);
    checkOutput({tag, " hold"}, respRdata, heldData);
  endtask

  initial begin
    int cnt;
    int lat;
    logic seen;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[9] = 8'h80; mem[62] = 8'hAA; mem[63] = 8'hBB;
    ackEn = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqFunc3 = 3'd0; reqAddr = '0; reqWdata = 32'd0;

    vecs[0]  = mk(0, 3'b010, 0,  0, 32'h44332211, 0, 5, 4);
    vecs[1]  = MIS ? mk(1, 3'b001, 5, 32'h0000BEEF, 0, 1, 1, 0)
                   : mk(1, 3'b001, 5, 32'h0000BEEF, 0, 0, 3, 2);
    vecs[2]  = MIS ? mk(0, 3'b001, 5, 0, 0, 1, 1, 0) : mk(0, 3'b001, 5, 0, 32'hFFFFBEEF, 0, 3, 2);
    vecs[3]  = MIS ? mk(0, 3'b101, 5, 0, 0, 1, 1, 0) : mk(0, 3'b101, 5, 0, 32'h0000BEEF, 0, 3, 2);
    vecs[4]  = mk(0, 3'b000, 9,  0, 32'hFFFFFF80, 0, 2, 1);
    vecs[5]  = mk(0, 3'b100, 9,  0, 32'h00000080, 0, 2, 1);
    vecs[6]  = MIS ? mk(0, 3'b010, 62, 0, 0, 1, 1, 0) : mk(0, 3'b010, 62, 0, 32'h2211BBAA, 0, 5, 4);
    vecs[7]  = mk(1, 3'b000, 4,  32'h12345677, 0, 0, 2, 1);
    vecs[8]  = mk(0, 3'b100, 4,  0, 32'h00000077, 0, 2, 1);
    vecs[9]  = mk(1, 3'b010, 8,  32'hA1B2C3D4, 0, 0, 5, 4);
    vecs[10] = mk(0, 3'b010, 8,  0, 32'hA1B2C3D4, 0, 5, 4);
    vecs[11] = mk(0, 3'b001, 2,  0, 32'h00004433, 0, 3, 2);
    vecs[12] = mk(1, 3'b100, 0,  32'hDEADBEEF, 0, 1, 1, 0);
    vecs[13] = mk(0, 3'b011, 0,  0, 0, 1, 1, 0);
    vecs[14] = mk(0, 3'b111, 0,  0, 0, 1, 1, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset ready", {31'd0, reqReady}, 32'd1);
    checkOutput("reset resp", {30'd0, respValid, respErr}, 32'd0);
    checkOutput("reset rdata", respRdata, 32'd0);
    checkOutput("reset mem", {16'd0, memReq, memWe, memAddr, memWdata}, 32'd0);

    for (int i = 0; i < 15; i++) runVector($sformatf("v%0d", i), vecs[i]);

    // Silent memory: the store must give up after the timeout window.
    ackEn = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunc3 = 3'b010; reqAddr = 6'd0; reqWdata = 32'h55667788;
    @(posedge clk);
    #1 reqValid = 1'b0;
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (memReq) cnt++;
      if (respValid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("timeout req cycles", cnt, 15);
    checkOutput("timeout resp", {31'd0, seen}, 32'd1);
    checkOutput("timeout err", {31'd0, respErr}, 32'd1);
    checkOutput("timeout rdata", respRdata, 32'd0);
    checkOutput("timeout mem untouched", {24'd0, mem[0]}, 32'h11);
    ackEn = 1'b1;

    // Reset in the middle of a word load while the third byte is on the bus.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqFunc3 = 3'b010; reqAddr = 6'd0; reqWdata = 32'd0;
    @(posedge clk);
    #1 reqValid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (memReq && memAddr == 6'd2) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("abort reached byte2", {31'd0, seen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort mem_req", {31'd0, memReq}, 32'd0);
    checkOutput("abort ready", {31'd0, reqReady}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (respValid) seen = 1'b1;
    end
    checkOutput("abort no resp", {31'd0, seen}, 32'd0);
    runVector("post-abort lb", mk(0, 3'b000, 0, 0, 32'h00000011, 0, 2, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
